regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 7 +
 rtl/regfile_wb_arbiter_rf_scoreboard.sv | 22 ++
 rtl/regfile_wb_arbiter.sv | 71 +++++++
 tb/tb_regfile_wb_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, register address type and arbitration state encoding.
package regfile_wb_arbiter_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    typedef logic [$clog2(NREG_DEF)-1:0] regAddr_t;
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} arbState_t;
endpackage

// File: rtl/regfile_wb_arbiter_rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits; a set beats a same-cycle clear, x0 never busy.
module rf_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    setEn,
    input  logic [$clog2(NREG)-1:0] setAddr,
    input  logic                    clrEn,
    input  logic [$clog2(NREG)-1:0] clrAddr,
    output logic [NREG-1:0]         busy
);
    logic [NREG-1:0] setMask, clrMask;
    always_comb begin
        setMask = (setEn && setAddr != '0) ? NREG'(1) << setAddr : '0;
        clrMask = clrEn ? NREG'(1) << clrAddr : '0;
    end
    always_ff @(posedge clk)
        busy <= rst ? '0 : ((busy & ~clrMask) | setMask) & ~NREG'(1);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-source writeback arbiter with registered RF write port and busy scoreboard.
// Define RF_WB_ROUND_ROBIN_EN for round-robin contention; otherwise s1 always wins.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_valid,
    output logic                    s0_ready,
    input  logic [$clog2(NREG)-1:0] s0_addr,
    input  logic [XLEN-1:0]         s0_data,
    input  logic                    s1_valid,
    output logic                    s1_ready,
    input  logic [$clog2(NREG)-1:0] s1_addr,
    input  logic [XLEN-1:0]         s1_data,
    input  logic                    resv_valid,
    input  logic [$clog2(NREG)-1:0] resv_addr,
    output logic [NREG-1:0]         busy,
    output logic                    rf_wen,
    output logic [$clog2(NREG)-1:0] rf_addr,
    output logic [XLEN-1:0]         rf_data
);
`ifdef RF_WB_ROUND_ROBIN_EN
    localparam bit rrEn = 1'b1;
`else
    localparam bit rrEn = 1'b0;
`endif
    arbState_t state, nextState;
    logic contended, preferS0, xfer;
    logic [$clog2(NREG)-1:0] selAddr;
    logic [XLEN-1:0] selData;
    always_ff @(posedge clk)
        state <= rst ? PRI0 : nextState;
    // Without round-robin the state never leaves PRI0, so s1 always wins contention.
    always_comb begin
        contended = s0_valid && s1_valid;
        preferS0  = rrEn && state == PRI0;
        nextState = (rrEn && contended && !rst) ? (preferS0 ? PRI1 : PRI0) : state;
        s0_ready  = !rst && s0_valid && (!s1_valid || preferS0);
        s1_ready  = !rst && s1_valid && (!s0_valid || !preferS0);
        xfer      = s0_ready || s1_ready;
        selAddr   = s1_ready ? s1_addr : s0_addr;
        selData   = s1_ready ? s1_data : s0_data;
    end
    // Writes to x0 are accepted but dropped here, so they never reach the RF or scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen  <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_wen <= xfer && selAddr != '0;
            if (xfer) begin
                rf_addr <= selAddr;
                rf_data <= selData;
            end
        end
    end
    rf_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .setEn  (resv_valid),
        .setAddr(resv_addr),
        .clrEn  (rf_wen),
        .clrAddr(rf_addr),
        .busy   (busy)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus hand sequences for reset and contention.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, s0_valid, s0_ready, s1_valid, s1_ready, resv_valid, rf_wen;
    logic [4:0] s0_addr, s1_addr, resv_addr, rf_addr;
    logic [31:0] s0_data, s1_data, rf_data, busy;
    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .resv_valid(resv_valid), .resv_addr(resv_addr), .busy(busy),
        .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    typedef struct {
        logic s0v; logic [4:0] s0a; logic [31:0] s0d;
        logic s1v; logic [4:0] s1a; logic [31:0] s1d;
        logic rv;  logic [4:0] ra;
        logic r0;  logic r1;
        logic wen; logic [4:0] wa; logic [31:0] wd;
        logic [31:0] bz;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic rv, input logic [4:0] ra);
        s0_valid = v0; s0_addr = a0; s0_data = d0;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
        resv_valid = rv; resv_addr = ra;
    endtask

    int expG[4];
    logic [4:0] qa0[3], qa1[3];
    logic [31:0] qd0[3], qd1[3];
    int i0, i1;

    initial begin
        vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[2]  = '{0, 0, 0, 1, 9, 32'h55, 0, 0, 0, 1, 1, 9, 32'h55, 32'h0};
        vt[3]  = '{1, 0, 32'h1234, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 32'h80};
        vt[5]  = '{0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 1, 7, 32'h77, 32'h80};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[7]  = '{1, 3, 32'h33, 0, 0, 0, 1, 3, 1, 0, 1, 3, 32'h33, 32'h8};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 32'h8};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8};
        vt[10] = '{1, 3, 32'h44, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'h44, 32'h8};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
`ifdef RF_WB_ROUND_ROBIN_EN
        expG = '{0, 1, 0, 1};
`else
        expG = '{1, 1, 0, 0};
`endif
        qa0 = '{5'd1, 5'd2, 5'd0}; qd0 = '{32'hA0, 32'hA1, 32'h0};
        qa1 = '{5'd11, 5'd12, 5'd0}; qd1 = '{32'hB0, 32'hB1, 32'h0};

        rst = 1'b1;
        drive(1, 4, 32'hF0, 1, 6, 32'hF1, 1, 7);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_s0_ready", 32'(s0_ready), 0);
            chk("rst_s1_ready", 32'(s1_ready), 0);
            @(posedge clk); #1;
            chk("rst_rf_wen", 32'(rf_wen), 0);
            chk("rst_busy", busy, 0);
        end
        rst = 1'b0;

        i0 = 0; i1 = 0;
        for (int c = 0; c < 4; c++) begin
            drive(i0 < 2, qa0[i0], qd0[i0], i1 < 2, qa1[i1], qd1[i1], 0, 0);
            #1;
            chk($sformatf("cont%0d_s0_ready", c), 32'(s0_ready), 32'(expG[c] == 0));
            chk($sformatf("cont%0d_s1_ready", c), 32'(s1_ready), 32'(expG[c] == 1));
            @(posedge clk); #1;
            chk($sformatf("cont%0d_rf_wen", c), 32'(rf_wen), 1);
            chk($sformatf("cont%0d_rf_addr", c), 32'(rf_addr), 32'(expG[c] == 0 ? qa0[i0] : qa1[i1]));
            chk($sformatf("cont%0d_rf_data", c), rf_data, expG[c] == 0 ? qd0[i0] : qd1[i1]);
            if (expG[c] == 0) i0++; else i1++;
        end

        for (int k = 0; k < 12; k++) begin
            drive(vt[k].s0v, vt[k].s0a, vt[k].s0d, vt[k].s1v, vt[k].s1a, vt[k].s1d, vt[k].rv, vt[k].ra);
            #1;
            chk($sformatf("vec%0d_s0_ready", k), 32'(s0_ready), 32'(vt[k].r0));
            chk($sformatf("vec%0d_s1_ready", k), 32'(s1_ready), 32'(vt[k].r1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rf_wen", k), 32'(rf_wen), 32'(vt[k].wen));
            if (vt[k].wen) begin
                chk($sformatf("vec%0d_rf_addr", k), 32'(rf_addr), 32'(vt[k].wa));
                chk($sformatf("vec%0d_rf_data", k), rf_data, vt[k].wd);
            end
            chk($sformatf("vec%0d_busy", k), busy, vt[k].bz);
        end

        drive(1, 6, 32'h66, 0, 0, 0, 1, 9);
        #1;
        chk("mid_s0_ready", 32'(s0_ready), 1);
        @(posedge clk); #1;
        chk("mid_rf_wen_pre", 32'(rf_wen), 1);
        chk("mid_busy_pre", busy, 32'h200);
        rst = 1'b1;
        drive(1, 6, 32'h66, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_s0_ready", 32'(s0_ready), 0);
        @(posedge clk); #1;
        chk("mid_rf_wen_post", 32'(rf_wen), 0);
        chk("mid_busy_post", busy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_s0_ready", 32'(s0_ready), 1);
        @(posedge clk); #1;
        chk("post_rst_rf_wen", 32'(rf_wen), 1);
        chk("post_rst_rf_addr", 32'(rf_addr), 6);
        chk("post_rst_busy", busy, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("final_rf_wen", 32'(rf_wen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
